uart_mmio_bridge: RTL and testbench
===================================

# uart_mmio_bridge

Memory-mapped front end for the `uart` block. It sits between the CPU data bus and `uart`. On the transmit side it buffers CPU writes in a TX FIFO and drives `tx_data`/`tx_enable` one byte at a time, pacing itself on `tx_status`. On the receive side it captures each `rx_data` byte on the `rx_status` pulse into an RX FIFO, and exposes status, control and an interrupt line to the CPU.

## Interface
- `TX_DEPTH`, default 4: TX FIFO entries; must be a power of 2, at least 2.
- `RX_DEPTH`, default 4: RX FIFO entries; must be a power of 2, at least 2.
- `BUSY_TIMEOUT`, default 1023: sysclk cycles to wait for `tx_status` to fall after a launch.
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  bridge selected.
- `rd`  in  1  read strobe, qualified by `cs`.
- `wr`  in  1  write strobe, qualified by `cs`.
- `addr`  in  2  word select: 0 TXD, 1 RXD, 2 STAT, 3 CTRL.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational.
- `irq`  out  1  level interrupt to the CPU.
- `tx_data`  out  8  byte to `uart`.
- `tx_enable`  out  1  one-cycle launch pulse to `uart`.
- `tx_status`  in  1  from `uart`; 1 means the transmitter is idle.
- `rx_data`  in  8  from `uart`; stable while `rx_status` is high.
- `rx_status`  in  1  from `uart`; high for one baud-x16 period per received byte.
- `rx_enable`  out  1  to `uart`.

## Operation
- **Reset values.** `tx_data`=0, `tx_enable`=0, `rx_enable`=0, `irq`=0. Both FIFOs empty, all sticky flags 0, CTRL=0, TX FSM in IDLE.
- `rx_enable` is a register that goes to 1 on the first clock edge after reset release.
- **Register writes** (`cs & wr`):
  - TXD: push `wdata[7:0]`. If the FIFO is full at that edge, the byte is dropped and `tx_ovf` is set; this holds even if a pop occurs in the same cycle.
  - STAT: write-1-to-clear. Bit3 clears `rx_ovr`, bit4 clears `tx_ovf`, bit5 clears `tx_err`.
  - CTRL: `[1:0]` are stored.
  - RXD: write is ignored.
- **Register reads** (`cs & rd`):
  - RXD: returns `{24'b0, head}` and pops on the edge. If the FIFO is empty, returns 0 with no pop.
  - STAT: bit0 `rx_avail` (RX not empty), bit1 `tx_full`, bit2 `tx_idle` (TX FIFO empty and FSM in IDLE), bit3 `rx_ovr`, bit4 `tx_ovf`, bit5 `tx_err`; other bits 0.
  - CTRL: returns `{30'b0, tx_irq_en, rx_irq_en}`.
  - TXD: returns 0.
- `rdata` is 0 whenever `cs & rd` is false.
- `irq` = (`rx_irq_en` & `rx_avail`) | (`tx_irq_en` & `tx_idle`), driven from registered state.
- **Input synchronisation.** `tx_status` and `rx_status` each pass through two flops (`txs_s`, `rxs_s`).
- **RX capture.** An RX event is a rising edge of `rxs_s`. On the event, `rx_data` is pushed to the RX FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and `rx_ovr` is set.
  - If the FIFO is full and a pop occurs in the same cycle, both the pop and the push happen and the count is unchanged.
- **TX FSM:**
  - IDLE: if the TX FIFO is not empty, pop the head into `tx_data` and go to LAUNCH.
  - LAUNCH: `tx_enable`=1 for this cycle only; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: if `txs_s`=0, go to WAIT_DONE. If the counter reaches `BUSY_TIMEOUT`, set `tx_err` and go to IDLE (the byte is lost). Otherwise increment the counter.
  - WAIT_DONE: if `txs_s`=1, go to IDLE.
- `tx_data` holds its value from LAUNCH until the next pop. `uart` samples it up to about 326 cycles after the pulse.
- The counter width is `clog2(BUSY_TIMEOUT+1)`. FIFO pointers are `log2(DEPTH)` bits, wrap naturally, and the count is one bit wider.
- **Reset mid-operation** (`reset_n` low at any point): immediately restore all reset values. Any in-flight byte in `uart` is not tracked.

## Timing
- TXD write at edge N with the FIFO empty and FSM in IDLE: the pop happens at edge N+1, and `tx_enable` is high in the cycle between edges N+1 and N+2.
- Back-to-back bytes: the next launch comes no earlier than 3 cycles after `txs_s` returns to 1.
- RX: `rx_status` rising before edge k makes `rx_avail` 1 after edge k+2. `irq` follows in the same cycle.
- RXD read pops at the read edge, and `rx_avail` updates after that edge.
- Writes to STAT/CTRL take effect after the write edge.

## Test plan
- **Reset.** Hold `reset_n`=0 mid-TX with data queued; release. Expect all outputs at reset values, STAT reads 0x04, and `rx_enable`=1 one cycle after release.
- **Single TX.** Write TXD 0x55. Expect exactly one `tx_enable` pulse with `tx_data`=0x55 one cycle after the write. The model drops `tx_status` 200 cycles later for 2000 cycles; expect `tx_idle`=1 three cycles after it rises.
- **TX overflow.** With `tx_status` held 0 after the first launch, write 0x01–0x06. Expect 0x02–0x05 queued, 0x06 dropped and `tx_ovf`=1, STAT bit1=1. Write STAT 0x10 and expect `tx_ovf` cleared.
- **TX timeout.** `tx_status` stuck at 1: write 0xA0. Expect `tx_err`=1 exactly `BUSY_TIMEOUT` cycles into WAIT_BUSY, then FSM in IDLE.
- **RX path.** Pulse `rx_status` for 163 cycles with `rx_data`=0x3C, with `rx_irq_en`=1. Expect `irq`=1 after 3 edges; RXD read returns 0x3C, after which `irq`=0 and a second read returns 0.
- **RX overflow and simultaneous pop.** Deliver 5 bytes with no reads. Expect `rx_ovr`=1 and the first 4 retained. Refill to full, then align a 6th event with an RXD read. Expect the pop to return the oldest byte, the new byte to be accepted, and the count to stay 4.

Source files
------------

// File: rtl/uart_mmio_bridge_if.sv
// CPU register bus plus the uart-side byte handshake of the bridge.
// The bridge uses the slave modport and the CPU/uart side uses master.
interface uart_mmio_bridge_if;
   logic        cs;
   logic        rd;
   logic        wr;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [7:0]  tx_data;
   logic        tx_enable;
   logic        tx_status;
   logic [7:0]  rx_data;
   logic        rx_status;
   logic        rx_enable;

   modport slave (
      input  cs, rd, wr, addr, wdata, tx_status, rx_data, rx_status,
      output rdata, irq, tx_data, tx_enable, rx_enable
   );

   modport master (
      output cs, rd, wr, addr, wdata, tx_status, rx_data, rx_status,
      input  rdata, irq, tx_data, tx_enable, rx_enable
   );
endinterface

// File: rtl/uart_mmio_bridge.sv
// Register front end for the uart block: TX FIFO feeding a launch sequencer,
// RX capture FIFO, sticky error flags, control bits and a level interrupt.
module uart_mmio_bridge #(
   parameter int TX_DEPTH     = 4,
   parameter int RX_DEPTH     = 4,
   parameter int BUSY_TIMEOUT = 1023
) (
   input  logic              sysclk,
   input  logic              reset_n,
   uart_mmio_bridge_if.slave bus
);
   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int RXAW = $clog2(RX_DEPTH);
   localparam int CNTW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TXAW:0]   TX_CNT_FULL = (TXAW + 1)'(TX_DEPTH);
   localparam logic [RXAW:0]   RX_CNT_FULL = (RXAW + 1)'(RX_DEPTH);
   localparam logic [CNTW-1:0] CNT_LIMIT   = CNTW'(BUSY_TIMEOUT);
   localparam logic [1:0] A_TXD  = 2'd0;
   localparam logic [1:0] A_RXD  = 2'd1;
   localparam logic [1:0] A_STAT = 2'd2;
   localparam logic [1:0] A_CTRL = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } tx_state_e;

   tx_state_e       state_q, state_d;
   logic [7:0]      tx_mem_q [TX_DEPTH];
   logic [7:0]      tx_mem_d [TX_DEPTH];
   logic [TXAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [TXAW:0]   tx_cnt_q, tx_cnt_d;
   logic [7:0]      rx_mem_q [RX_DEPTH];
   logic [7:0]      rx_mem_d [RX_DEPTH];
   logic [RXAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [RXAW:0]   rx_cnt_q, rx_cnt_d;
   logic [CNTW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_enable_q, tx_enable_d;
   logic            rx_enable_q, rx_enable_d;
   logic            irq_q, irq_d;
   logic [1:0]      txs_sync_q, txs_sync_d, rxs_sync_q, rxs_sync_d;
   logic            rxs_prev_q, rxs_prev_d;
   logic            rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d, tx_err_q, tx_err_d;
   logic [1:0]      ctrl_q, ctrl_d;

   logic        rd_sel_s, wr_sel_s, txs_s, rx_event_s;
   logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, tx_idle_s;
   logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, tx_err_set_s, rx_ovr_set_s;
   logic [31:0] stat_s, rdata_s;

   // Bus decode, FIFO status and the two-flop input synchronisers.
   always_comb begin
      rd_sel_s   = bus.cs & bus.rd;
      wr_sel_s   = bus.cs & bus.wr;
      txs_s      = txs_sync_q[1];
      rx_event_s = rxs_sync_q[1] & ~rxs_prev_q;
      tx_full_s  = (tx_cnt_q == TX_CNT_FULL);
      tx_empty_s = (tx_cnt_q == '0);
      rx_full_s  = (rx_cnt_q == RX_CNT_FULL);
      rx_empty_s = (rx_cnt_q == '0);
      tx_idle_s  = tx_empty_s & (state_q == S_IDLE);
      txs_sync_d = {txs_sync_q[0], bus.tx_status};
      rxs_sync_d = {rxs_sync_q[0], bus.rx_status};
      rxs_prev_d = rxs_sync_q[1];
      rx_enable_d = 1'b1;
   end

   // TX FIFO and launch sequencer; a full FIFO drops the write even if a pop coincides.
   always_comb begin
      state_d      = state_q;
      tx_data_d    = tx_data_q;
      to_cnt_d     = to_cnt_q;
      tx_err_set_s = 1'b0;
      tx_pop_s     = 1'b0;
      tx_mem_d     = tx_mem_q;
      tx_push_s    = wr_sel_s & (bus.addr == A_TXD) & ~tx_full_s;
      case (state_q)
         S_IDLE: begin
            if (!tx_empty_s) begin
               tx_pop_s  = 1'b1;
               tx_data_d = tx_mem_q[tx_rp_q];
               state_d   = S_LAUNCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            to_cnt_d = '0;
            state_d  = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!txs_s) begin
               state_d = S_WAIT_DONE;
            end else if (to_cnt_q == CNT_LIMIT) begin
               tx_err_set_s = 1'b1;
               state_d      = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + CNTW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (txs_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (tx_push_s) begin
         tx_mem_d[tx_wp_q] = bus.wdata[7:0];
      end else begin
         tx_mem_d[tx_wp_q] = tx_mem_q[tx_wp_q];
      end
      tx_wp_d     = tx_wp_q + TXAW'(tx_push_s);
      tx_rp_d     = tx_rp_q + TXAW'(tx_pop_s);
      tx_cnt_d    = tx_cnt_q + (TXAW + 1)'(tx_push_s) - (TXAW + 1)'(tx_pop_s);
      tx_enable_d = (state_d == S_LAUNCH);
   end

   // RX FIFO: a capture into a full FIFO survives only when a read frees a slot that edge.
   always_comb begin
      rx_mem_d     = rx_mem_q;
      rx_pop_s     = rd_sel_s & (bus.addr == A_RXD) & ~rx_empty_s;
      rx_push_s    = rx_event_s & (~rx_full_s | rx_pop_s);
      rx_ovr_set_s = rx_event_s & rx_full_s & ~rx_pop_s;
      if (rx_push_s) begin
         rx_mem_d[rx_wp_q] = bus.rx_data;
      end else begin
         rx_mem_d[rx_wp_q] = rx_mem_q[rx_wp_q];
      end
      rx_wp_d  = rx_wp_q + RXAW'(rx_push_s);
      rx_rp_d  = rx_rp_q + RXAW'(rx_pop_s);
      rx_cnt_d = rx_cnt_q + (RXAW + 1)'(rx_push_s) - (RXAW + 1)'(rx_pop_s);
   end

   // Sticky flags (set beats a simultaneous clear), control bits and the next irq level.
   always_comb begin
      rx_ovr_d = rx_ovr_q;
      tx_ovf_d = tx_ovf_q;
      tx_err_d = tx_err_q;
      ctrl_d   = ctrl_q;
      if (wr_sel_s && (bus.addr == A_STAT)) begin
         rx_ovr_d = rx_ovr_q & ~bus.wdata[3];
         tx_ovf_d = tx_ovf_q & ~bus.wdata[4];
         tx_err_d = tx_err_q & ~bus.wdata[5];
      end else if (wr_sel_s && (bus.addr == A_CTRL)) begin
         ctrl_d = bus.wdata[1:0];
      end else begin
         ctrl_d = ctrl_q;
      end
      rx_ovr_d = rx_ovr_d | rx_ovr_set_s;
      tx_ovf_d = tx_ovf_d | (wr_sel_s & (bus.addr == A_TXD) & tx_full_s);
      tx_err_d = tx_err_d | tx_err_set_s;
      irq_d    = (ctrl_d[0] & (rx_cnt_d != '0))
               | (ctrl_d[1] & (tx_cnt_d == '0) & (state_d == S_IDLE));
   end

   // Combinational read mux.
   always_comb begin
      stat_s  = {26'd0, tx_err_q, tx_ovf_q, rx_ovr_q, tx_idle_s, tx_full_s, ~rx_empty_s};
      rdata_s = 32'd0;
      if (rd_sel_s) begin
         case (bus.addr)
            A_RXD:   rdata_s = rx_empty_s ? 32'd0 : {24'd0, rx_mem_q[rx_rp_q]};
            A_STAT:  rdata_s = stat_s;
            A_CTRL:  rdata_s = {30'd0, ctrl_q};
            default: rdata_s = 32'd0;
         endcase
      end else begin
         rdata_s = 32'd0;
      end
   end

   // State registers.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'd0;
         for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'd0;
         tx_wp_q     <= '0;
         tx_rp_q     <= '0;
         tx_cnt_q    <= '0;
         rx_wp_q     <= '0;
         rx_rp_q     <= '0;
         rx_cnt_q    <= '0;
         to_cnt_q    <= '0;
         tx_data_q   <= 8'd0;
         tx_enable_q <= 1'b0;
         rx_enable_q <= 1'b0;
         irq_q       <= 1'b0;
         txs_sync_q  <= 2'b00;
         rxs_sync_q  <= 2'b00;
         rxs_prev_q  <= 1'b0;
         rx_ovr_q    <= 1'b0;
         tx_ovf_q    <= 1'b0;
         tx_err_q    <= 1'b0;
         ctrl_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         tx_mem_q    <= tx_mem_d;
         rx_mem_q    <= rx_mem_d;
         tx_wp_q     <= tx_wp_d;
         tx_rp_q     <= tx_rp_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_wp_q     <= rx_wp_d;
         rx_rp_q     <= rx_rp_d;
         rx_cnt_q    <= rx_cnt_d;
         to_cnt_q    <= to_cnt_d;
         tx_data_q   <= tx_data_d;
         tx_enable_q <= tx_enable_d;
         rx_enable_q <= rx_enable_d;
         irq_q       <= irq_d;
         txs_sync_q  <= txs_sync_d;
         rxs_sync_q  <= rxs_sync_d;
         rxs_prev_q  <= rxs_prev_d;
         rx_ovr_q    <= rx_ovr_d;
         tx_ovf_q    <= tx_ovf_d;
         tx_err_q    <= tx_err_d;
         ctrl_q      <= ctrl_d;
      end
   end

   assign bus.rdata     = rdata_s;
   assign bus.irq       = irq_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_enable = tx_enable_q;
   assign bus.rx_enable = rx_enable_q;
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: register table, TX/RX corner
// sequences, then randomized RX/register traffic against a queue model.
module tb_uart_mmio_bridge;
   localparam int BT = 1023;
   localparam logic [1:0] TXD = 2'd0, RXD = 2'd1, STAT = 2'd2, CTRL = 2'd3;

   logic sysclk  = 1'b0;
   logic reset_n = 1'b0;
   always #5 sysclk = ~sysclk;

   uart_mmio_bridge_if bus_if ();
   uart_mmio_bridge #(.TX_DEPTH(4), .RX_DEPTH(4), .BUSY_TIMEOUT(BT)) dut (
      .sysclk (sysclk),
      .reset_n(reset_n),
      .bus    (bus_if)
   );

   int n_checks  = 0;
   int n_fail    = 0;
   int tx_pulses = 0;
   logic [7:0] tx_log [$];

   typedef struct {
      logic        is_wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;
   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
      if (bus_if.tx_enable === 1'b1) begin
         tx_pulses++;
         tx_log.push_back(bus_if.tx_data);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
      tick();
      bus_if.cs = 1'b0; bus_if.wr = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = a;
      #1;
      d = bus_if.rdata;
      tick();
      bus_if.cs = 1'b0; bus_if.rd = 1'b0;
   endtask

   // Look at a register without crossing a clock edge (never used on RXD).
   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = a;
      #1;
      d = bus_if.rdata;
      bus_if.cs = 1'b0; bus_if.rd = 1'b0;
   endtask

   task automatic wait_launch(input string name);
      int n0 = tx_pulses;
      for (int i = 0; i < 64 && tx_pulses == n0; i++) tick();
      check(name, 32'(tx_pulses - n0), 32'd1);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      bus_if.rx_data = b; bus_if.rx_status = 1'b1;
      ticks(4);
      bus_if.rx_status = 1'b0;
      ticks(4);
   endtask

   initial begin
      logic [31:0] d;
      int          n0;
      int          base;
      bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = 2'd0;
      bus_if.wdata = 32'd0; bus_if.tx_status = 1'b1; bus_if.rx_data = 8'd0; bus_if.rx_status = 1'b0;

      vecs[0]  = '{1'b0, STAT, 32'd0,         32'h04, 1'b0};
      vecs[1]  = '{1'b0, TXD,  32'd0,         32'h00, 1'b0};
      vecs[2]  = '{1'b0, RXD,  32'd0,         32'h00, 1'b0};
      vecs[3]  = '{1'b0, CTRL, 32'd0,         32'h00, 1'b0};
      vecs[4]  = '{1'b1, CTRL, 32'hFFFF_FFFD, 32'h00, 1'b0};
      vecs[5]  = '{1'b0, CTRL, 32'd0,         32'h01, 1'b0};
      vecs[6]  = '{1'b1, CTRL, 32'h0000_0002, 32'h00, 1'b1};
      vecs[7]  = '{1'b0, CTRL, 32'd0,         32'h02, 1'b1};
      vecs[8]  = '{1'b1, RXD,  32'h0000_00AB, 32'h00, 1'b1};
      vecs[9]  = '{1'b0, RXD,  32'd0,         32'h00, 1'b1};
      vecs[10] = '{1'b1, STAT, 32'h0000_003F, 32'h00, 1'b1};
      vecs[11] = '{1'b0, STAT, 32'd0,         32'h04, 1'b1};
      vecs[12] = '{1'b1, CTRL, 32'h0000_0000, 32'h00, 1'b0};

      ticks(3);
      check("por_tx_enable", 32'(bus_if.tx_enable), 32'd0);
      check("por_rx_enable", 32'(bus_if.rx_enable), 32'd0);
      reset_n = 1'b1;
      ticks(3);

      // Reset mid-operation: one byte in flight, one still queued.
      bus_if.tx_status = 1'b0;
      n0 = tx_pulses;
      bus_write(TXD, 32'h11);
      bus_write(TXD, 32'h22);
      ticks(4);
      check("rst_pre_pulses", 32'(tx_pulses - n0), 32'd1);
      check("rst_pre_tx_data", 32'(bus_if.tx_data), 32'h11);
      #1 reset_n = 1'b0;
      #1;
      check("rst_tx_data", 32'(bus_if.tx_data), 32'h00);
      check("rst_tx_enable", 32'(bus_if.tx_enable), 32'd0);
      check("rst_irq", 32'(bus_if.irq), 32'd0);
      check("rst_rx_enable", 32'(bus_if.rx_enable), 32'd0);
      ticks(2);
      bus_if.tx_status = 1'b1;
      reset_n = 1'b1;
      #1;
      check("rst_rx_enable_before_edge", 32'(bus_if.rx_enable), 32'd0);
      tick();
      check("rst_rx_enable_after_edge", 32'(bus_if.rx_enable), 32'd1);
      peek(STAT, d);
      check("rst_stat", d, 32'h04);
      n0 = tx_pulses;
      ticks(10);
      check("rst_queue_flushed", 32'(tx_pulses - n0), 32'd0);

      // Register access table.
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].is_wr) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
         end else begin
            bus_read(vecs[i].addr, d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
         end
         check($sformatf("vec%0d_irq", i), 32'(bus_if.irq), 32'(vecs[i].exp_irq));
      end

      // Single TX with uart busy for 2000 cycles.
      n0 = tx_pulses;
      bus_write(TXD, 32'h55);
      check("tx1_no_pulse_yet", 32'(bus_if.tx_enable), 32'd0);
      tick();
      check("tx1_pulse", 32'(bus_if.tx_enable), 32'd1);
      check("tx1_data", 32'(bus_if.tx_data), 32'h55);
      ticks(199);
      bus_if.tx_status = 1'b0;
      ticks(2000);
      bus_if.tx_status = 1'b1;
      tick();
      peek(STAT, d);
      check("tx1_idle_e1", 32'(d[2]), 32'd0);
      tick();
      peek(STAT, d);
      check("tx1_idle_e2", 32'(d[2]), 32'd0);
      tick();
      peek(STAT, d);
      check("tx1_idle_e3", d, 32'h04);
      check("tx1_one_pulse", 32'(tx_pulses - n0), 32'd1);
      check("tx1_data_held", 32'(bus_if.tx_data), 32'h55);

      // TX overflow with the uart held busy.
      bus_if.tx_status = 1'b0;
      n0 = tx_pulses;
      for (int b = 1; b <= 6; b++) bus_write(TXD, 32'(b));
      peek(STAT, d);
      check("ovf_stat", d, 32'h12);
      check("ovf_one_launch", 32'(tx_pulses - n0), 32'd1);
      check("ovf_first_byte", 32'(bus_if.tx_data), 32'h01);
      bus_write(STAT, 32'h10);
      peek(STAT, d);
      check("ovf_cleared", d, 32'h02);
      base = tx_log.size();
      bus_if.tx_status = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_launch($sformatf("drain_launch%0d", i));
         bus_if.tx_status = 1'b0;
         ticks(8);
         bus_if.tx_status = 1'b1;
      end
      ticks(5);
      for (int i = 0; i < 4; i++)
         check($sformatf("drain_byte%0d", i),
               (tx_log.size() > base + i) ? 32'(tx_log[base + i]) : 32'hDEAD, 32'(i + 2));
      peek(STAT, d);
      check("drain_stat", d, 32'h04);

      // TX timeout with tx_status stuck idle.
      bus_write(TXD, 32'hA0);
      ticks(BT + 2);
      peek(STAT, d);
      check("to_before", d, 32'h00);
      tick();
      peek(STAT, d);
      check("to_err", d, 32'h24);
      check("to_byte", (tx_log.size() > 0) ? 32'(tx_log[$]) : 32'hDEAD, 32'hA0);
      bus_write(STAT, 32'h20);
      peek(STAT, d);
      check("to_cleared", d, 32'h04);

      // RX path with the receive interrupt enabled.
      bus_write(CTRL, 32'h1);
      bus_if.rx_data = 8'h3C; bus_if.rx_status = 1'b1;
      #1;
      check("rx_irq_e0", 32'(bus_if.irq), 32'd0);
      tick();
      check("rx_irq_e1", 32'(bus_if.irq), 32'd0);
      tick();
      check("rx_irq_e2", 32'(bus_if.irq), 32'd0);
      tick();
      check("rx_irq_e3", 32'(bus_if.irq), 32'd1);
      ticks(160);
      bus_if.rx_status = 1'b0;
      ticks(3);
      bus_read(RXD, d);
      check("rx_read", d, 32'h3C);
      check("rx_irq_after_read", 32'(bus_if.irq), 32'd0);
      bus_read(RXD, d);
      check("rx_read_empty", d, 32'h00);

      // RX overflow, then a capture coinciding with a pop of a full FIFO.
      for (int b = 0; b < 5; b++) rx_pulse(8'(8'hA1 + b));
      peek(STAT, d);
      check("rxo_stat", d, 32'h0D);
      for (int b = 0; b < 4; b++) begin
         bus_read(RXD, d);
         check($sformatf("rxo_byte%0d", b), d, 32'(8'hA1 + b));
      end
      bus_read(RXD, d);
      check("rxo_empty", d, 32'h00);
      bus_write(STAT, 32'h08);
      for (int b = 0; b < 4; b++) rx_pulse(8'(8'hB1 + b));
      bus_if.rx_data = 8'hC6; bus_if.rx_status = 1'b1;
      ticks(2);
      bus_read(RXD, d);
      check("align_pop", d, 32'hB1);
      peek(STAT, d);
      check("align_no_ovr", d, 32'h05);
      ticks(2);
      bus_if.rx_status = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus_read(RXD, d);
         check($sformatf("align_byte%0d", b), d, (b < 3) ? 32'(8'hB2 + b) : 32'hC6);
      end
      bus_read(RXD, d);
      check("align_empty", d, 32'h00);
      ticks(4);

      // Randomized RX traffic and register accesses against a queue model.
      begin : rand_phase
         logic [7:0]  mq [$];
         logic        m_ovr, rise, prev_st, ovr_set, exp_irq;
         logic [1:0]  m_ctrl;
         logic        pv [2];
         logic [7:0]  pd [2];
         logic [31:0] w, exp_d;
         int          op, hold;
         m_ovr = 1'b0; m_ctrl = 2'b01; prev_st = 1'b0; hold = 0;
         pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = 8'd0; pd[1] = 8'd0;
         for (int it = 0; it < 600; it++) begin
            if (hold == 0) begin
               bus_if.rx_status = ~bus_if.rx_status;
               if (bus_if.rx_status) bus_if.rx_data = 8'($urandom);
               hold = $urandom_range(3, 8);
            end
            hold--;
            rise    = bus_if.rx_status & ~prev_st;
            prev_st = bus_if.rx_status;
            op = $urandom_range(0, 7);
            w  = $urandom;
            bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.wdata = w;
            case (op)
               3: begin bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = RXD;  end
               4: begin bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = STAT; end
               5: begin bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = CTRL; end
               6: begin bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = STAT; end
               7: begin bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = CTRL; end
               default: bus_if.addr = 2'($urandom);
            endcase
            #1;
            exp_irq = (m_ctrl[0] & (mq.size() != 0)) | m_ctrl[1];
            check($sformatf("rnd%0d_irq", it), 32'(bus_if.irq), 32'(exp_irq));
            exp_d = 32'd0;
            if (op == 3) exp_d = (mq.size() != 0) ? 32'(mq[0]) : 32'd0;
            if (op == 4) exp_d = {28'd0, m_ovr, 1'b1, 1'b0, mq.size() != 0};
            if (op == 5) exp_d = {30'd0, m_ctrl};
            if (op != 6 && op != 7) check($sformatf("rnd%0d_rdata", it), bus_if.rdata, exp_d);
            tick();
            // Reference update for the edge just taken.
            if (op == 3 && mq.size() != 0) void'(mq.pop_front());
            ovr_set = 1'b0;
            if (pv[1]) begin
               if (mq.size() < 4) mq.push_back(pd[1]);
               else ovr_set = 1'b1;
            end
            if (op == 6 && w[3]) m_ovr = 1'b0;
            if (ovr_set) m_ovr = 1'b1;
            if (op == 7) m_ctrl = w[1:0];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = rise;  pd[0] = bus_if.rx_data;
         end
         bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
